dv_debug_apb_master: RTL and testbench

//  APB initiator for the debug com bus: turns one command (addr, write flag, 48-bit data)

---
 rtl/dv_debug_apb_master.sv | 148 ++++++++++++++
 tb/tb_dv_debug_apb_master.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dv_debug_apb_master.sv
// dv_debug_apb_master
//   APB initiator for the debug com bus. It takes one command (address, direction,
//   write data) and runs it as a single APB SETUP/ACCESS transfer. The read data and
//   status come back on a valid/ready response channel.
// Ports
//   clk, rstn                       clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o         command handshake; cmd_write_i, cmd_addr_i, cmd_wdata_i
//   rsp_valid_o/rsp_ready_i         response handshake; rsp_rdata_o, rsp_err_o, rsp_timeout_o
//   busy_o                          high whenever a command is in flight
//   psel_o, penable_o, paddr_o, pwdata_o, pwrite_o, prdata_i, pready_i, pslverr_i  APB side
module dv_debug_apb_master #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 48,
    parameter int unsigned TIMEOUT = 256,  // 0 = wait forever
    parameter int unsigned TO_W    = 9     // 2**TO_W > TIMEOUT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o,
    output logic              busy_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic [DATA_W-1:0] pwdata_o,
    output logic              pwrite_o,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pready_i,
    input  logic              pslverr_i
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e              state_q, state_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                to_q, to_d;
    logic [TO_W-1:0]     cnt_q, cnt_d;
    logic                to_hit;

    // Last permitted ACCESS cycle without pready; pready on that same cycle still wins.
    assign to_hit = (TIMEOUT != 0) && (cnt_q == TO_W'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        to_d      = to_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    paddr_d  = cmd_addr_i;
                    pwdata_d = cmd_wdata_i;
                    pwrite_d = cmd_write_i;
                    psel_d   = 1'b1;
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                cnt_d     = '0;
                psel_d    = 1'b1;
                penable_d = 1'b1;
                state_d   = StAccess;
            end
            StAccess: begin
                if (pready_i) begin
                    rdata_d = pwrite_q ? '0 : prdata_i;
                    err_d   = pslverr_i;
                    to_d    = 1'b0;
                    state_d = StResp;
                end else if (to_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d     = cnt_q + TO_W'(1);
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            to_q      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            to_q      <= to_d;
            cnt_q     <= cnt_d;
        end
    end

    assign cmd_ready_o   = (state_q == StIdle);
    assign rsp_valid_o   = (state_q == StResp);
    assign busy_o        = (state_q != StIdle);
    assign rsp_rdata_o   = rdata_q;
    assign rsp_err_o     = err_q;
    assign rsp_timeout_o = to_q;
    assign psel_o        = psel_q;
    assign penable_o     = penable_q;
    assign paddr_o       = paddr_q;
    assign pwdata_o      = pwdata_q;
    assign pwrite_o      = pwrite_q;

endmodule

// File: tb/tb_dv_debug_apb_master.sv
// Directed bench for dv_debug_apb_master, built with TIMEOUT=8. Inputs change on the
// falling edge; outputs are sampled on the falling edge before inputs are updated.
module tb_dv_debug_apb_master;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 48;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              cmd_valid_i = 1'b0;
    logic              cmd_ready_o;
    logic              cmd_write_i = 1'b0;
    logic [ADDR_W-1:0] cmd_addr_i = '0;
    logic [DATA_W-1:0] cmd_wdata_i = '0;
    logic              rsp_valid_o;
    logic              rsp_ready_i = 1'b0;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic              rsp_err_o;
    logic              rsp_timeout_o;
    logic              busy_o;
    logic              psel_o;
    logic              penable_o;
    logic [ADDR_W-1:0] paddr_o;
    logic [DATA_W-1:0] pwdata_o;
    logic              pwrite_o;
    logic [DATA_W-1:0] prdata_i = '0;
    logic              pready_i = 1'b0;
    logic              pslverr_i = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dv_debug_apb_master #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(8),
        .TO_W   (4)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_write_i  (cmd_write_i),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_wdata_i  (cmd_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .rsp_timeout_o(rsp_timeout_o),
        .busy_o       (busy_o),
        .psel_o       (psel_o),
        .penable_o    (penable_o),
        .paddr_o      (paddr_o),
        .pwdata_o     (pwdata_o),
        .pwrite_o     (pwrite_o),
        .prdata_i     (prdata_i),
        .pready_i     (pready_i),
        .pslverr_i    (pslverr_i)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One transfer. waits = ACCESS cycles with pready low before pready is raised;
    // exp_acc = expected number of ACCESS cycles; hold = cycles rsp_ready stays low.
    task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [47:0] wdata, input logic [47:0] slv_rdata,
                        input int waits, input logic slverr, input int hold,
                        input int exp_acc, input logic [47:0] exp_rdata,
                        input logic exp_err, input logic exp_to);
        int acc;
        logic done;
        @(negedge clk);
        check_eq({tag, " cmd_ready idle"}, 64'(cmd_ready_o), 64'd1);
        cmd_valid_i = 1'b1;
        cmd_write_i = wr;
        cmd_addr_i  = addr;
        cmd_wdata_i = wdata;
        @(negedge clk);
        // SETUP: change command inputs to prove they are ignored now
        cmd_valid_i = 1'b0;
        cmd_addr_i  = ~addr;
        cmd_wdata_i = ~wdata;
        cmd_write_i = ~wr;
        check_eq({tag, " setup psel"}, 64'(psel_o), 64'd1);
        check_eq({tag, " setup penable"}, 64'(penable_o), 64'd0);
        check_eq({tag, " setup paddr"}, 64'(paddr_o), 64'(addr));
        check_eq({tag, " setup pwrite"}, 64'(pwrite_o), 64'(wr));
        check_eq({tag, " setup pwdata"}, 64'(pwdata_o), 64'(wdata));
        acc  = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (rsp_valid_o) begin
                done = 1'b1;
            end else begin
                acc++;
                if (psel_o !== 1'b1 || penable_o !== 1'b1 || paddr_o !== addr ||
                    pwdata_o !== wdata || pwrite_o !== wr)
                    check_eq({tag, " access bus stable"},
                             {psel_o, penable_o, pwrite_o}, {1'b1, 1'b1, wr});
                pready_i  = (acc == waits + 1);
                pslverr_i = slverr;
                prdata_i  = slv_rdata;
            end
        end
        pready_i  = 1'b0;
        pslverr_i = 1'b0;
        prdata_i  = 48'hDEAD_BEEF_0000;
        check_eq({tag, " rsp_valid seen"}, 64'(done), 64'd1);
        check_eq({tag, " access cycles"}, 64'(acc), 64'(exp_acc));
        rsp_ready_i = 1'b0;
        for (int h = 0; h < hold; h++) begin
            check_eq({tag, " hold rsp_valid"}, 64'(rsp_valid_o), 64'd1);
            check_eq({tag, " hold cmd_ready"}, 64'(cmd_ready_o), 64'd0);
            check_eq({tag, " hold psel"}, 64'({psel_o, penable_o}), 64'd0);
            check_eq({tag, " hold rdata"}, 64'(rsp_rdata_o), 64'(exp_rdata));
            @(negedge clk);
        end
        check_eq({tag, " rdata"}, 64'(rsp_rdata_o), 64'(exp_rdata));
        check_eq({tag, " err"}, 64'(rsp_err_o), 64'(exp_err));
        check_eq({tag, " timeout"}, 64'(rsp_timeout_o), 64'(exp_to));
        check_eq({tag, " rsp psel"}, 64'({psel_o, penable_o}), 64'd0);
        check_eq({tag, " rsp cmd_ready"}, 64'(cmd_ready_o), 64'd0);
        check_eq({tag, " rsp paddr kept"}, 64'(paddr_o), 64'(addr));
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        check_eq({tag, " back idle"}, 64'({busy_o, rsp_valid_o, cmd_ready_o}), 64'b001);
    endtask

    initial begin
        #1;
        check_eq("reset cmd_ready", 64'(cmd_ready_o), 64'd1);
        check_eq("reset outs", 64'({psel_o, penable_o, rsp_valid_o, busy_o, pwrite_o,
                                    rsp_err_o, rsp_timeout_o}), 64'd0);
        check_eq("reset paddr", 64'(paddr_o), 64'd0);
        check_eq("reset rdata", 64'(rsp_rdata_o), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        // tag wr addr wdata slv_rdata waits slverr hold exp_acc exp_rdata err to
        xfer("t1 read", 1'b0, 32'h0, 48'h0, 48'h1234, 0, 1'b0, 0, 1, 48'h1234, 1'b0, 1'b0);
        xfer("t2 write", 1'b1, 32'h18, 48'hA5A5_5A5A, 48'h7777, 0, 1'b0, 0, 1, 48'h0,
             1'b0, 1'b0);
        xfer("t3 wait3", 1'b0, 32'h40, 48'h0, 48'hBEEF, 3, 1'b0, 0, 4, 48'hBEEF, 1'b0, 1'b0);
        xfer("t4 slverr", 1'b0, 32'h44, 48'h0, 48'h55, 0, 1'b1, 0, 1, 48'h55, 1'b1, 1'b0);
        xfer("t4 next", 1'b0, 32'h48, 48'h0, 48'h66, 0, 1'b0, 0, 1, 48'h66, 1'b0, 1'b0);
        xfer("t5 timeout", 1'b0, 32'h80, 48'h0, 48'h99, 100, 1'b0, 0, 8, 48'h0, 1'b1, 1'b1);
        xfer("t5 pready8", 1'b0, 32'h84, 48'h0, 48'hABC, 7, 1'b0, 0, 8, 48'hABC, 1'b0, 1'b0);
        xfer("t6 hold", 1'b1, 32'h90, 48'h1_0000_0001, 48'h0, 1, 1'b0, 5, 2, 48'h0,
             1'b0, 1'b0);

        // t6 reset during ACCESS
        @(negedge clk);
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'b0;
        cmd_addr_i  = 32'hC0;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        @(negedge clk);
        check_eq("t6 in access", 64'({psel_o, penable_o}), 64'b11);
        #2 rstn = 1'b0;
        #1;
        check_eq("t6 rst drop", 64'({psel_o, penable_o, rsp_valid_o, busy_o}), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check_eq("t6 cmd_ready after rst", 64'(cmd_ready_o), 64'd1);
        check_eq("t6 no rsp after rst", 64'(rsp_valid_o), 64'd0);
        xfer("t6 after", 1'b0, 32'hC4, 48'h0, 48'h4242, 0, 1'b0, 0, 1, 48'h4242, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
